// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the emulated shared bus: pops one packet at a time
// from the pending device FIFOs and routes it by destination ID, dropping invalid ones.
module bus_arbiter #(
  parameter int unsigned width     = 16,
  parameter int unsigned devices   = 4,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [devices-1:0]               pndng_i,
  input  logic [devices-1:0][width-1:0]    dato_i,
  output logic [devices-1:0]               pop_o,
  output logic [devices-1:0]               push_o,
  output logic [width-1:0]                 dato_o,
  output logic                             busy_o,
  output logic [7:0]                       drop_cnt_o
);

  localparam int unsigned idx_w = (devices > 1) ? $clog2(devices) : 1;

  typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

  state_t               state;
  logic [idx_w-1:0]     last_grant;
  logic [idx_w-1:0]     src;
  logic [idx_w-1:0]     grant;
  logic [idx_w-1:0]     cand;
  logic [width-1:0]     pkt;
  logic [7:0]           dst;
  logic [devices-1:0]   push_mask;
  logic                 drop;

  // Round-robin search: lowest offset after last_grant wins, so scan offsets high to low.
  always_comb begin
    grant = last_grant;
    cand  = last_grant;
    for (int unsigned i = devices; i >= 1; i--) begin
      cand = idx_w'((32'(last_grant) + i) % devices);
      if (pndng_i[cand]) grant = cand;
    end
  end

  // Destination decode of the latched packet.
  always_comb begin
    dst       = pkt[width-1 -: 8];
    push_mask = '0;
    drop      = 1'b0;
    if ((dst < 8'(devices)) && (dst != 8'(src))) begin
      push_mask = devices'(1) << dst;
    end else if (dst == broadcast) begin
      push_mask = ~(devices'(1) << src);
    end else begin
      drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= idx_w'(devices - 1);
      pkt        <= '0;
      src        <= '0;
      pop_o      <= '0;
      push_o     <= '0;
      dato_o     <= '0;
      busy_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      pop_o  <= '0;
      push_o <= '0;
      case (state)
        POP: begin
          dato_o <= pkt;
          push_o <= push_mask;
          if (drop && (drop_cnt_o != 8'hFF)) drop_cnt_o <= drop_cnt_o + 8'd1;
          state  <= SEND;
        end
        // IDLE and SEND share the grant/latch path; SEND may chain straight into POP.
        default: begin
          if (|pndng_i) begin
            pkt        <= dato_i[grant];
            src        <= grant;
            last_grant <= grant;
            pop_o      <= devices'(1) << grant;
            busy_o     <= 1'b1;
            state      <= POP;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: models the device FIFOs as queues and checks
// grant order, routing, drop counting and asynchronous reset behaviour.
module tb_bus_arbiter;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          pndng_i;
  logic [N-1:0][W-1:0]   dato_i;
  logic [N-1:0]          pop_o;
  logic [N-1:0]          push_o;
  logic [W-1:0]          dato_o;
  logic                  busy_o;
  logic [7:0]            drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] fifo [N][$];
  int           pop_log[$];
  int           pop_cyc[$];
  logic [N-1:0] push_mask_log[$];
  logic [W-1:0] push_data_log[$];

  bus_arbiter #(.width(W), .devices(N), .broadcast(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .pndng_i(pndng_i), .dato_i(dato_i),
    .pop_o(pop_o), .push_o(push_o), .dato_o(dato_o),
    .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    for (int d = 0; d < N; d++) begin
      pndng_i[d] = (fifo[d].size() != 0);
      dato_i[d]  = pndng_i[d] ? fifo[d][0] : '0;
    end
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    push_mask_log.delete();
    push_data_log.delete();
  endtask

  // One clock: observe at the falling edge, apply FIFO pops, log bus traffic.
  task automatic step();
    @(negedge clk);
    cyc++;
    checks++;
    if ($countones(pop_o) > 1) begin
      errors++;
      $display("FAIL pop_onehot: pop_o=%b, required at most one bit set", pop_o);
    end
    for (int d = 0; d < N; d++) begin
      if (pop_o[d]) begin
        checks++;
        if (fifo[d].size() == 0) begin
          errors++;
          $display("FAIL pop_empty: pop_o=%b on empty device %0d", pop_o, d);
        end else begin
          void'(fifo[d].pop_front());
        end
        pop_log.push_back(d);
        pop_cyc.push_back(cyc);
      end
    end
    if (push_o != '0) begin
      push_mask_log.push_back(push_o);
      push_data_log.push_back(dato_o);
    end
    refresh();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    step();
    while ((busy_o || (|pndng_i)) && (n < budget)) begin
      step();
      n++;
    end
    checks++;
    if (busy_o || (|pndng_i)) begin
      errors++;
      $display("FAIL drain_timeout: busy_o=%b pndng_i=%b after %0d cycles, required idle", busy_o, pndng_i, budget);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pndng_i = '0;
    dato_i  = '0;
    #1;
    checks++;
    if ({pop_o, push_o, dato_o, busy_o, drop_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pop=%b push=%b dato=%h busy=%b drop=%0d, required all 0",
               pop_o, push_o, dato_o, busy_o, drop_cnt_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pop_o !== '0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: pop=%b busy=%b, required 0 and 0", pop_o, busy_o);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_mask;
    logic [W-1:0] exp_data;
    clear_logs();
    for (int d = 0; d < N; d++)
      for (int k = 0; k < 2; k++)
        fifo[d].push_back({8'((d + 1) % N), 8'(d * 16 + k)});
    refresh();
    drain(100);
    checks++;
    if (pop_log.size() != 8 || push_mask_log.size() != 8) begin
      errors++;
      $display("FAIL rr_count: pops=%0d pushes=%0d, required 8 and 8", pop_log.size(), push_mask_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_mask = N'(1) << ((i + 1) % N);
        exp_data = {8'((i + 1) % N), 8'((i % N) * 16 + i / N)};
        checks++;
        if (pop_log[i] != i % N) begin
          errors++;
          $display("FAIL rr_order: pop %0d went to device %0d, required %0d", i, pop_log[i], i % N);
        end
        checks++;
        if (push_mask_log[i] !== exp_mask || push_data_log[i] !== exp_data) begin
          errors++;
          $display("FAIL rr_push: push %0d mask=%b data=%h, required %b %h",
                   i, push_mask_log[i], push_data_log[i], exp_mask, exp_data);
        end
        if (i > 0) begin
          checks++;
          if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
            errors++;
            $display("FAIL rr_spacing: pop %0d gap %0d cycles, required 2", i, pop_cyc[i] - pop_cyc[i-1]);
          end
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_busy_end: busy_o=%b, required 0", busy_o);
    end
  endtask

  task automatic test_unicast();
    fifo[1].push_back(16'h0212);
    refresh();
    step();
    checks++;
    if (pop_o !== 4'b0010 || push_o !== 4'b0000 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL uni_pop: pop=%b push=%b busy=%b, required 0010 0000 1", pop_o, push_o, busy_o);
    end
    step();
    checks++;
    if (push_o !== 4'b0100 || dato_o !== 16'h0212 || pop_o !== 4'b0000) begin
      errors++;
      $display("FAIL uni_send: push=%b dato=%h pop=%b, required 0100 0212 0000", push_o, dato_o, pop_o);
    end
    step();
    checks++;
    if (push_o !== 4'b0000 || busy_o !== 1'b0 || pop_o !== 4'b0000) begin
      errors++;
      $display("FAIL uni_idle: push=%b busy=%b pop=%b, required 0000 0 0000", push_o, busy_o, pop_o);
    end
  endtask

  task automatic test_broadcast();
    fifo[2].push_back(16'hFF5A);
    refresh();
    step();
    checks++;
    if (pop_o !== 4'b0100) begin
      errors++;
      $display("FAIL bc_pop: pop=%b, required 0100", pop_o);
    end
    step();
    checks++;
    if (push_o !== 4'b1011 || dato_o !== 16'hFF5A || drop_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL bc_send: push=%b dato=%h drop=%0d, required 1011 ff5a 0", push_o, dato_o, drop_cnt_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || push_o !== 4'b0000) begin
      errors++;
      $display("FAIL bc_idle: busy=%b push=%b, required 0 0000", busy_o, push_o);
    end
  endtask

  task automatic test_drops();
    clear_logs();
    fifo[0].push_back(16'h0705);
    fifo[0].push_back(16'h0011);
    refresh();
    drain(20);
    checks++;
    if (push_mask_log.size() != 0 || pop_log.size() != 2 || drop_cnt_o !== 8'd2) begin
      errors++;
      $display("FAIL drop_two: pushes=%0d pops=%0d drop=%0d, required 0 2 2",
               push_mask_log.size(), pop_log.size(), drop_cnt_o);
    end
    for (int i = 0; i < 300; i++) fifo[0].push_back(16'h0900);
    refresh();
    drain(1000);
    checks++;
    if (drop_cnt_o !== 8'd255 || push_mask_log.size() != 0) begin
      errors++;
      $display("FAIL drop_saturate: drop=%0d pushes=%0d, required 255 0", drop_cnt_o, push_mask_log.size());
    end
  endtask

  task automatic test_reset_in_pop();
    fifo[3].push_back(16'h0012);
    refresh();
    step();
    checks++;
    if (pop_o !== 4'b1000) begin
      errors++;
      $display("FAIL rip_pop: pop=%b, required 1000", pop_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pop_o !== '0 || push_o !== '0 || busy_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL rip_async: pop=%b push=%b busy=%b drop=%0d, required 0 0 0 0",
               pop_o, push_o, busy_o, drop_cnt_o);
    end
    for (int d = 0; d < N; d++) fifo[d].delete();
    fifo[0].push_back(16'h0100);
    fifo[3].push_back(16'h0200);
    refresh();
    clear_logs();
    step();
    rst_n = 1'b1;
    drain(20);
    checks++;
    if (pop_log.size() != 2 || push_mask_log.size() != 2) begin
      errors++;
      $display("FAIL rip_count: pops=%0d pushes=%0d, required 2 2", pop_log.size(), push_mask_log.size());
    end else begin
      checks++;
      if (pop_log[0] != 0 || pop_log[1] != 3) begin
        errors++;
        $display("FAIL rip_order: pops %0d,%0d, required 0,3", pop_log[0], pop_log[1]);
      end
      checks++;
      if (push_mask_log[0] !== 4'b0010 || push_data_log[0] !== 16'h0100 ||
          push_mask_log[1] !== 4'b0100 || push_data_log[1] !== 16'h0200) begin
        errors++;
        $display("FAIL rip_push: %b/%h then %b/%h, required 0010/0100 then 0100/0200",
                 push_mask_log[0], push_data_log[0], push_mask_log[1], push_data_log[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_unicast();
    test_broadcast();
    test_drops();
    test_reset_in_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus controller sitting directly downstream of the per-device `fifo` instances in the emulated shared bus. It polls the pending flags of `devices` transmit FIFOs and pops one packet at a time from the granted FIFO. It decodes the destination ID carried in the packet header and pushes the packet into the destination device's receive side, or into every other device for a broadcast. Invalid and self-addressed packets are dropped and counted.

## Interface
- `width`, 16: packet width in bits; must be ≥ 9; bits `[width-1:width-8]` are the destination ID.
- `devices`, 4: number of attached devices; range 2..16.
- `broadcast`, 8'hFF: destination ID meaning "all devices except source".

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pndng_i`  in  devices  bit d = FIFO d non-empty.
- `dato_i`  in  devices×width  head word of FIFO d (show-ahead: valid while `pndng_i[d]`=1, before pop).
- `pop_o`  out  devices  one-hot, one-cycle pop strobe to FIFO d.
- `push_o`  out  devices  one-cycle push strobe(s) to receive side of device d.
- `dato_o`  out  width  packet driven on the bus; valid when any `push_o` bit is 1.
- `busy_o`  out  1  high in POP and SEND states.
- `drop_cnt_o`  out  8  saturating count of dropped packets.

## Operation
- FSM states: IDLE, POP, SEND.
- IDLE: if `|pndng_i`, compute grant g = first d with `pndng_i[d]`=1, searching from `last_grant+1` upward, modulo `devices`. On the edge: latch `pkt <= dato_i[g]`, `src <= g`, `last_grant <= g`, go to POP. Otherwise stay in IDLE.
- POP: `pop_o[src]`=1 for exactly this cycle. Decode `dst = pkt[width-1 -: 8]`. Go to SEND.
- SEND: `dato_o = pkt`.
  - If `dst < devices` and `dst != src`: `push_o = 1<<dst`.
  - If `dst == broadcast`: `push_o` = all ones except bit `src`.
  - Otherwise (out of range, or equal to `src`): `push_o` = 0, and `drop_cnt_o` increments, saturating at 255.
  - Exit from SEND: if `|pndng_i`, perform the IDLE grant/latch action and go directly to POP. Otherwise go to IDLE.
- `pndng_i[src]` sampled in SEND already reflects the pop made in POP. No masking is applied.
- Outputs `pop_o`, `push_o`, `busy_o` and `drop_cnt_o` are registered or decoded from registered state only. There are no combinational paths from `pndng_i` or `dato_i` to any output.
- Reset values: state IDLE, `last_grant = devices-1` (so device 0 wins first), `pkt`=0, `src`=0, and `pop_o`, `push_o`, `dato_o`, `busy_o`, `drop_cnt_o` all 0.
- `dato_o` retains the last packet outside SEND; consumers qualify it with `push_o`.

## Timing
- Latency:
  - `pndng_i` seen high in IDLE at cycle t.
  - `pop_o` is high in cycle t+1.
  - `push_o`/`dato_o` are valid in cycle t+2.
- Throughput: one packet per 2 cycles under continuous demand (SEND→POP back-to-back).
- `pop_o` is never asserted for a device whose `pndng_i` was 0 at the grant edge. At most one `pop_o` bit is high per cycle.
- Fairness: with all devices continuously pending, grants rotate 0,1,…,devices-1,0.
- Simultaneous pending: round-robin priority only. There is no fixed priority.
- Async reset mid-transaction (POP or SEND): `pop_o`/`push_o` drop to 0 immediately without a clock edge, and the in-flight packet is lost. If the pop already occurred, it is not undone. After release, the first grant goes to the lowest pending device.
- Counter saturation: at 255, further drops leave `drop_cnt_o` at 255.

## Test plan
- Reset: assert `rst_n`=0 mid-run → all outputs 0 within the same timestep; after release, `busy_o`=0 and no pops while `pndng_i`=0.
- Unicast: `devices`=4, `pndng_i`=4'b0010, `dato_i[1]`=16'h0212 → `pop_o`=4'b0010 for one cycle, next cycle `push_o`=4'b0100 and `dato_o`=16'h0212, then IDLE once `pndng_i`=0.
- Round robin: all four FIFOs hold 2 packets each with valid destinations → pop order 0,1,2,3,0,1,2,3, one pop every 2 cycles, 8 pushes total, then `busy_o`=0.
- Broadcast: device 2 sends 16'hFF5A → `push_o`=4'b1011, `dato_o`=16'hFF5A, `drop_cnt_o` unchanged.
- Drops: device 0 sends 16'h0705 (out of range), then 16'h0011 (self) → `push_o` stays 0 in both SEND cycles, `drop_cnt_o`=2; then 300 more invalid packets → `drop_cnt_o`=255.
- Reset in POP: pulse `rst_n` low during the POP cycle of a device 3 transfer → `pop_o` clears asynchronously, no `push_o` follows; with `pndng_i`=4'b1001 after release, device 0 is granted first.
